// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308-style SPI ADC reader.
// Frame FSM states, config word and SDI bit selection.
package adc_pkg;

  localparam int ADC_BITS = 12;
  localparam logic [5:0] CFG_WORD = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } state_t;

  typedef logic [4:0] bit_cnt_t;

  // Config bit for SCK period k: cfg MSB first, zeros once exhausted.
  function automatic logic cfg_bit(
    input logic [5:0] cfg,
    input bit_cnt_t   k
  );
    logic [31:0] seq;
    seq = {cfg, 26'b0} << k;
    return seq[31];
  endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// SPI pin bundle between the reader (master) and the ADC (slave).
// Signal names follow the ADC pin roles seen from the reader.
interface adc_spi_reader_if;
  logic o_adc_convst;
  logic o_adc_sck;
  logic o_adc_sdi;
  logic i_adc_sdo;

  modport master (
    output o_adc_convst,
    output o_adc_sck,
    output o_adc_sdi,
    input  i_adc_sdo
  );

  modport slave (
    input  o_adc_convst,
    input  o_adc_sck,
    input  o_adc_sdi,
    output i_adc_sdo
  );
endinterface

// File: rtl/adc_sck_gen.sv
// SCK generator: clk_div-cycle low/high phases, rise/fall strobes.
// Strobes mark the clk whose closing edge flips the registered SCK.
module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int clk_div = 2,
  parameter int nbits   = ADC_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output logic     sck,
  output logic     rise,
  output logic     fall,
  output logic     last,
  output bit_cnt_t bit_cnt
);

  localparam int DW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(clk_div - 1);
  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(nbits - 1);

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = en && (div == DIV_MAX);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;
  assign last = fall && (bit_cnt == LAST_BIT);

  // Phase divider, SCK flop and completed-period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
    end else if (!en) begin
      div     <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) sck <= ~sck;
      if (fall) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// ADC capture stage: periodic CONVST, 12-bit SPI read, offset binary
// to two's complement, one o_sample/o_valid strobe per frame.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int         bits_per_level = ADC_BITS,
  parameter int         clk_div        = 2,
  parameter int         conv_cycles    = 80,
  parameter int         sample_period  = 1042,
  parameter logic [5:0] cfg_word       = CFG_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  adc_spi_reader_if.master          adc,
  output logic [bits_per_level-1:0] o_sample,
  output logic                      o_valid,
  output logic                      o_busy
);

  localparam int MIN_PERIOD =
    conv_cycles + 2 * bits_per_level * clk_div + 3;

  generate
    if (sample_period < MIN_PERIOD) begin : g_period_check
      $error("adc_spi_reader: sample_period=%0d < conv_cycles + 24*clk_div + 3 = %0d",
             sample_period, MIN_PERIOD);
    end
  endgenerate

  localparam int PW = $clog2(sample_period);
  localparam logic [PW-1:0] P_MAX = PW'(sample_period - 1);
  localparam int CW = (conv_cycles > 1) ? $clog2(conv_cycles) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(conv_cycles - 1);
  localparam int MSB = bits_per_level - 1;

  state_t                state;
  logic [PW-1:0]         period_cnt;
  logic [CW-1:0]         conv_cnt;
  logic [bits_per_level-1:0] sh;
  logic                  tick;
  logic                  shift_en;
  logic                  rise;
  logic                  fall;
  logic                  last;
  bit_cnt_t              bit_cnt;

  assign tick     = (period_cnt == '0) && i_enable && (state == IDLE);
  assign shift_en = (state == SHIFT);

  adc_sck_gen #(
    .clk_div (clk_div),
    .nbits   (bits_per_level)
  ) u_sck (
    .clk     (clk),
    .rst     (rst),
    .en      (shift_en),
    .sck     (adc.o_adc_sck),
    .rise    (rise),
    .fall    (fall),
    .last    (last),
    .bit_cnt (bit_cnt)
  );

  // Frame-rate counter; parked at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!i_enable || period_cnt == P_MAX) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Frame FSM with registered CONVST, SDI, sample and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      conv_cnt         <= '0;
      sh               <= '0;
      o_sample         <= '0;
      o_valid          <= 1'b0;
      o_busy           <= 1'b0;
      adc.o_adc_convst <= 1'b0;
      adc.o_adc_sdi    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state            <= CONV;
            conv_cnt         <= '0;
            o_busy           <= 1'b1;
            adc.o_adc_convst <= 1'b1;
          end
        end
        CONV: begin
          if (conv_cnt == C_MAX) begin
            state            <= SHIFT;
            adc.o_adc_convst <= 1'b0;
            adc.o_adc_sdi    <= cfg_bit(cfg_word, '0);
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (rise) sh <= {sh[MSB-1:0], adc.i_adc_sdo};
          if (fall) adc.o_adc_sdi <= cfg_bit(cfg_word, bit_cnt + 1'b1);
          if (last) begin
            state         <= DONE;
            o_valid       <= 1'b1;
            o_sample      <= {~sh[MSB], sh[MSB-1:0]};
            adc.o_adc_sdi <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
Front-end capture stage that runs an LTC2308-style 12-bit SPI ADC at a fixed audio sample rate. Each frame issues a conversion, shifts the result out, and converts it from offset binary to two's complement. The block presents one o_sample/o_valid pair per frame. Its outputs drive i_sample/valid of effects_pipeline directly.

Parameters:
bits_per_level, 12, ADC word width and o_sample width
clk_div, 2, SCK half-period in clk cycles (SCK period = 2*clk_div)
conv_cycles, 80, clk cycles CONVST is held high (conversion time; 1.6 us at 50 MHz)
sample_period, 1042, clk cycles between frame starts (about 48 kHz at 50 MHz)
cfg_word, 6'b100010, ADC config bits shifted out on SDI MSB first (single-ended ch0, unipolar)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_enable  in  1  permits new frames to start
i_adc_sdo  in  1  ADC serial data out
o_adc_convst  out  1  conversion start to ADC
o_adc_sck  out  1  serial clock to ADC
o_adc_sdi  out  1  config serial data to ADC
o_sample  out  bits_per_level  last captured sample, two's complement
o_valid  out  1  one-cycle strobe when o_sample updates
o_busy  out  1  high while a frame is in progress

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, period counter 0, shift register 0. If reset hits mid-frame, the frame is aborted and CONVST/SCK drop immediately. There is no partial o_valid.
- Period counter:
  - Counts 0..sample_period-1 and wraps while i_enable=1.
  - Held at 0 while i_enable=0.
  - tick = (counter==0) & i_enable & state==IDLE.
- FSM IDLE -> CONV -> SHIFT -> DONE -> IDLE:
  - IDLE: on tick at cycle T, go to CONV. o_busy=0.
  - CONV: o_adc_convst=1 for exactly conv_cycles cycles (T+1 .. T+conv_cycles), then SHIFT.
  - SHIFT:
    - Convst=0; 12 SCK periods, each clk_div cycles low then clk_div cycles high.
    - SDI updates at the start of each low phase: bit k (k=0..5) = cfg_word[5-k], bits 6..11 = 0.
    - SDO is sampled on the clk where SCK rises and shifted in MSB first.
    - Lasts 24*clk_div cycles; SCK is low on exit.
  - DONE: one cycle. Registers o_sample <= {~sh[11], sh[10:0]} (offset binary to two's complement) and pulses o_valid=1.
- Latency: o_valid is high in cycle T+1+conv_cycles+24*clk_div; o_busy is high for all CONV/SHIFT/DONE cycles.
- o_sample holds its value between strobes; o_valid is never high two consecutive cycles.
- i_enable dropping mid-frame: the frame completes normally, no further frames start. On re-enable the counter is at 0, so a frame starts on the first enabled cycle.
- Constraint: sample_period >= conv_cycles + 24*clk_div + 3. Violation is an elaboration-time error via a generate-time check.
- SCK, CONVST and SDI are driven from flops only (glitch-free).

Decomposition:
- Package adc_pkg: FSM state enum (IDLE, CONV, SHIFT, DONE), default cfg_word constant, ADC_BITS=12.
- Sub-module adc_sck_gen: clk_div counter producing registered sck plus one-cycle rise/fall strobes and a bit counter, enabled only in SHIFT.
- Top holds the FSM, period counter, shift register and output registers.

Test Plan:
Bench parameters: clk_div=1, conv_cycles=4, sample_period=40. ADC model drives SDO on SCK falling edges.
1. Reset released, i_enable=1, model returns 12'hA5C -> o_adc_convst high cycles 1-4, 12 SCK pulses cycles 5-28, o_valid only at cycle 29 with o_sample=12'h25C.
2. Model returns 12'h800, 12'h000, 12'hFFF on consecutive frames -> o_sample 12'h000, 12'h800, 12'h7FF; o_valid strobes exactly 40 cycles apart.
3. Capture SDI on SCK rising edges -> 1,0,0,0,1,0 then six 0s each frame.
4. i_enable dropped at cycle 10 of a frame -> that frame's o_valid still at cycle 29, no convst thereafter. Re-enable -> convst rises the next cycle.
5. rst pulsed at cycle 15 (mid-SHIFT) -> sck/convst/o_busy/o_sample/o_valid 0 in the same cycle, no o_valid for the aborted frame. After release, a new frame starts from the counter at 0.
6. sample_period=20 with the above params -> elaboration fails with the constraint message.
